// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: data word, RAM handshake state and arbiter FSM state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
  parameter int WIDTH = 4,
  parameter int MAX   = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             at_max
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clr)
      count <= '0;
    else if (inc && (count != MAX_V))
      count <= count + WIDTH'(1);
  end

  assign at_max = (count == MAX_V);

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one RAM port between icache (read-only) and dcache (read/write); data side has
// priority, with bounded instruction starvation and a per-transaction timeout.
module cache_mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int    STARVE_MAX  = 4,
  parameter int    TIMEOUT_CYC = 64,
  parameter word_t ERR_WORD    = 32'hBAD1BAD1
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      bus_err
);

  arb_state_t state;
  logic [3:0] starve_cnt;
  logic [7:0] tmo_cnt;
  logic       starve_full, tmo_full;
  logic       d_req, granted, req_live, withdraw, ok_done, err_done, done;

  assign d_req = dREN || dWEN;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    granted  = (state != IDLE);
    req_live = 1'b0;
    case (state)
      DGRANT:  req_live = d_req;
      IGRANT:  req_live = iREN;
      default: req_live = 1'b0;
    endcase
    withdraw = granted && !req_live;
    ok_done  = granted && req_live && (ramstate == ACCESS);
    // ACCESS beats a coincident timeout, so only a non-ACCESS cycle can fail.
    err_done = granted && req_live && !ok_done && ((ramstate == ERROR) || tmo_full);
    done     = ok_done || err_done;
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    bus_err  = err_done;
    case (state)
      DGRANT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN && !dWEN;
        dwait    = !done;
        dload    = err_done ? ERR_WORD : ramload;
      end
      IGRANT: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        iwait   = !done;
        iload   = err_done ? ERR_WORD : ramload;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (iREN && starve_full) state <= IGRANT;
          else if (d_req)          state <= DGRANT;
          else if (iREN)           state <= IGRANT;
        end
        DGRANT, IGRANT: begin
          if (done || withdraw) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  sat_counter #(.WIDTH(4), .MAX(STARVE_MAX)) u_starve_cnt (
    .clk    (CLK),
    .rst    (RST),
    .inc    (done && (state == DGRANT) && iREN),
    .clr    (done && ((state == IGRANT) || !iREN)),
    .count  (starve_cnt),
    .at_max (starve_full)
  );

  sat_counter #(.WIDTH(8), .MAX(TIMEOUT_CYC - 1)) u_tmo_cnt (
    .clk    (CLK),
    .rst    (RST),
    .inc    (granted && !done && !withdraw),
    .clr    (!granted || done || withdraw),
    .count  (tmo_cnt),
    .at_max (tmo_full)
  );

endmodule
